// File: rtl/draw_cmd_queue.sv
// Line-draw command queue: range-checks 52-bit commands against a 640x480 frame and
// feeds them one at a time to the line drawing engine. Optional stats: DRAW_CMD_QUEUE_STATS_EN.
module draw_cmd_queue #(
    parameter int DEPTH = 16,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst_,
    input  logic [51:0]   in_op,
    input  logic          in_rts,
    output logic          in_rtr,
    output logic [51:0]   out_op,
    output logic          out_rts,
    input  logic          out_rtr,
    input  logic          flush,
    input  logic          clr_err,
    output logic [AW:0]   count,
    output logic          busy,
    output logic          reject_err
`ifdef DRAW_CMD_QUEUE_STATS_EN
    ,
    output logic [15:0]   issued_cnt,
    output logic [7:0]    reject_cnt
`endif
);

    // state   | meaning
    // S_EMPTY | output register holds nothing, out_rts low
    // S_FULL  | output register holds the oldest command, out_rts high
    typedef enum logic {
        S_EMPTY = 1'b0,
        S_FULL  = 1'b1
    } state_t;

    localparam int            SLOTS    = DEPTH - 1;
    localparam logic [AW-1:0] PTR_LAST = AW'(SLOTS - 1);
    localparam logic [AW:0]   CAP      = (AW + 1)'(DEPTH);
    localparam logic [9:0]    X_MAX    = 10'd639;
    localparam logic [9:0]    Y_MAX    = 10'd479;

    state_t          r_state;
    state_t          w_state_nxt;
    logic [51:0]     r_mem [0:SLOTS-1];
    logic [AW-1:0]   r_wr_ptr;
    logic [AW-1:0]   r_rd_ptr;
    logic [AW:0]     r_count;
    logic [51:0]     r_out_op;
    logic            r_reject_err;

    logic            w_accept;
    logic            w_in_range;
    logic            w_push;
    logic            w_reject;
    logic            w_issue;
    logic [AW:0]     w_fifo_cnt;
    logic            w_fifo_nempty;
    logic            w_pop;
    logic            w_fifo_wr;
    logic            w_load_in;

    assign w_in_range = (in_op[51:42] <= X_MAX) && (in_op[31:22] <= X_MAX) &&
                        (in_op[41:32] <= Y_MAX) && (in_op[21:12] <= Y_MAX);

    assign in_rtr   = !flush && (r_count < CAP);
    assign w_accept = in_rts && in_rtr;
    assign w_push   = w_accept && w_in_range;
    assign w_reject = w_accept && !w_in_range;
    assign w_issue  = (r_state == S_FULL) && out_rtr;

    // The output register is part of count; the FIFO holds whatever is left.
    assign w_fifo_cnt    = r_count - {{AW{1'b0}}, (r_state == S_FULL)};
    assign w_fifo_nempty = (w_fifo_cnt != '0);

    always_ff @(posedge clk) begin
        if (rst_) begin
            r_state <= S_EMPTY;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_pop       = 1'b0;
        w_fifo_wr   = 1'b0;
        w_load_in   = 1'b0;
        case (r_state)
            S_EMPTY: begin
                if (w_fifo_nempty) begin
                    w_pop       = 1'b1;
                    w_fifo_wr   = w_push;
                    w_state_nxt = S_FULL;
                end else if (w_push) begin
                    w_load_in   = 1'b1;
                    w_state_nxt = S_FULL;
                end
            end
            S_FULL: begin
                if (w_issue) begin
                    if (w_fifo_nempty) begin
                        w_pop     = 1'b1;
                        w_fifo_wr = w_push;
                    end else if (w_push) begin
                        w_load_in = 1'b1;
                    end else begin
                        w_state_nxt = S_EMPTY;
                    end
                end else begin
                    w_fifo_wr = w_push;
                end
            end
            default: w_state_nxt = S_EMPTY;
        endcase
        if (flush) begin
            w_state_nxt = S_EMPTY;
            w_pop       = 1'b0;
            w_fifo_wr   = 1'b0;
            w_load_in   = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (w_fifo_wr) begin
            r_mem[r_wr_ptr] <= in_op;
        end
    end

    always_ff @(posedge clk) begin
        if (rst_) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else if (flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_fifo_wr) begin
                r_wr_ptr <= (r_wr_ptr == PTR_LAST) ? '0 : r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= (r_rd_ptr == PTR_LAST) ? '0 : r_rd_ptr + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst_) begin
            r_out_op <= '0;
        end else if (w_pop) begin
            r_out_op <= r_mem[r_rd_ptr];
        end else if (w_load_in) begin
            r_out_op <= in_op;
        end
    end

    always_ff @(posedge clk) begin
        if (rst_) begin
            r_count <= '0;
        end else if (flush) begin
            r_count <= '0;
        end else begin
            r_count <= r_count + (AW + 1)'(w_push) - (AW + 1)'(w_issue);
        end
    end

    // A reject in the same cycle as clr_err keeps the flag set.
    always_ff @(posedge clk) begin
        if (rst_) begin
            r_reject_err <= 1'b0;
        end else if (w_reject) begin
            r_reject_err <= 1'b1;
        end else if (clr_err) begin
            r_reject_err <= 1'b0;
        end
    end

`ifdef DRAW_CMD_QUEUE_STATS_EN
    logic [15:0] r_issued_cnt;
    logic [7:0]  r_reject_cnt;

    always_ff @(posedge clk) begin
        if (rst_) begin
            r_issued_cnt <= '0;
            r_reject_cnt <= '0;
        end else begin
            if (w_issue) begin
                r_issued_cnt <= r_issued_cnt + 16'd1;
            end
            if (w_reject && (r_reject_cnt != 8'hFF)) begin
                r_reject_cnt <= r_reject_cnt + 8'd1;
            end
        end
    end

    assign issued_cnt = r_issued_cnt;
    assign reject_cnt = r_reject_cnt;
`endif

    assign out_op     = r_out_op;
    assign out_rts    = (r_state == S_FULL);
    assign count      = r_count;
    assign busy       = (r_count != '0);
    assign reject_err = r_reject_err;

endmodule

// File: tb/tb_draw_cmd_queue.sv
// Bench for draw_cmd_queue: queue-level reference model checked every cycle,
// plus literal expectations at the directed-test milestones.
module tb_draw_cmd_queue;

    localparam int DEPTH = 16;
    localparam int AW    = $clog2(DEPTH);

    logic          clk = 1'b0;
    logic          rst_ = 1'b1;
    logic [51:0]   in_op = '0;
    logic          in_rts = 1'b0;
    logic          in_rtr;
    logic [51:0]   out_op;
    logic          out_rts;
    logic          out_rtr = 1'b0;
    logic          flush = 1'b0;
    logic          clr_err = 1'b0;
    logic [AW:0]   count;
    logic          busy;
    logic          reject_err;
`ifdef DRAW_CMD_QUEUE_STATS_EN
    logic [15:0]   issued_cnt;
    logic [7:0]    reject_cnt;
`endif

    draw_cmd_queue #(.DEPTH(DEPTH)) dut (
        .clk(clk), .rst_(rst_),
        .in_op(in_op), .in_rts(in_rts), .in_rtr(in_rtr),
        .out_op(out_op), .out_rts(out_rts), .out_rtr(out_rtr),
        .flush(flush), .clr_err(clr_err),
        .count(count), .busy(busy), .reject_err(reject_err)
`ifdef DRAW_CMD_QUEUE_STATS_EN
        , .issued_cnt(issued_cnt), .reject_cnt(reject_cnt)
`endif
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [51:0] mk(input int x0, input int y0, input int x1,
                                       input int y1, input int c);
        return {10'(x0), 10'(y0), 10'(x1), 10'(y1), 12'(c)};
    endfunction

    // Reference model: the queue contents in order, head = what must be on out_op.
    logic [51:0] m_q[$];
    logic        m_err  = 1'b0;
    int          m_iss  = 0;
    int          m_rej  = 0;
    bit          live   = 1'b0;
    bit          m_issue, m_acc, m_ok;
    logic [51:0] m_cmd;

    always @(posedge clk) begin
        if (rst_) begin
            m_q.delete();
            m_err = 1'b0;
            m_iss = 0;
            m_rej = 0;
            live  = 1'b1;
        end else if (live) begin
            m_issue = (m_q.size() > 0) && out_rtr;
            m_acc   = in_rts && !flush && (m_q.size() < DEPTH);
            m_cmd   = in_op;
            m_ok    = (m_cmd[51:42] < 640) && (m_cmd[31:22] < 640) &&
                      (m_cmd[41:32] < 480) && (m_cmd[21:12] < 480);
            if (m_issue) begin
                void'(m_q.pop_front());
                m_iss = (m_iss + 1) % 65536;
            end
            if (flush) m_q.delete();
            if (m_acc && m_ok) m_q.push_back(m_cmd);
            if (m_acc && !m_ok) begin
                m_err = 1'b1;
                if (m_rej < 255) m_rej++;
            end else if (clr_err) begin
                m_err = 1'b0;
            end
        end
    end

    always @(negedge clk) begin
        if (live && !rst_) begin
            chk("in_rtr", 64'(in_rtr), 64'(!flush && (m_q.size() < DEPTH)));
            chk("out_rts", 64'(out_rts), 64'(m_q.size() > 0));
            chk("count", 64'(count), 64'(m_q.size()));
            chk("busy", 64'(busy), 64'(m_q.size() != 0));
            chk("reject_err", 64'(reject_err), 64'(m_err));
            if (m_q.size() > 0) chk("out_op", 64'(out_op), 64'(m_q[0]));
`ifdef DRAW_CMD_QUEUE_STATS_EN
            chk("issued_cnt", 64'(issued_cnt), 64'(m_iss));
            chk("reject_cnt", 64'(reject_cnt), 64'(m_rej));
`endif
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [51:0] c);
        in_op  = c;
        in_rts = 1'b1;
        step();
        in_rts = 1'b0;
    endtask

    initial begin
        step();
        step();
        rst_ = 1'b0;
        chk("rst count", 64'(count), 64'd0);
        chk("rst out_rts", 64'(out_rts), 64'd0);
        chk("rst out_op", 64'(out_op), 64'd0);
        chk("rst in_rtr", 64'(in_rtr), 64'd1);
        chk("rst reject_err", 64'(reject_err), 64'd0);

        // Full-frame diagonal passes straight through with one cycle latency.
        out_rtr = 1'b1;
        push(mk(0, 0, 639, 479, 12'hFFF));
        chk("t1 out_rts", 64'(out_rts), 64'd1);
        chk("t1 out_op", 64'(out_op), 64'h0000_9FDD_FFFF);
        chk("t1 count1", 64'(count), 64'd1);
        step();
        chk("t1 count0", 64'(count), 64'd0);
        chk("t1 out_rts0", 64'(out_rts), 64'd0);

        // Fill beyond capacity with the engine stalled, then drain in order.
        out_rtr = 1'b0;
        for (int i = 0; i < 20; i++) begin
            in_op  = mk(i, i, i + 1, i + 1, i);
            in_rts = 1'b1;
            step();
        end
        chk("t2 full count", 64'(count), 64'd16);
        chk("t2 full in_rtr", 64'(in_rtr), 64'd0);
        in_rts  = 1'b0;
        out_rtr = 1'b1;
        for (int i = 0; i < 16; i++) begin
            chk("t2 drain op", 64'(out_op), 64'(mk(i, i, i + 1, i + 1, i)));
            step();
        end
        chk("t2 empty", 64'(count), 64'd0);

        // Out-of-range commands are dropped and flagged.
        out_rtr = 1'b0;
        push(mk(0, 0, 640, 0, 1));
        chk("t3 err", 64'(reject_err), 64'd1);
        chk("t3 count", 64'(count), 64'd0);
`ifdef DRAW_CMD_QUEUE_STATS_EN
        chk("t3 reject_cnt", 64'(reject_cnt), 64'd1);
`endif
        clr_err = 1'b1;
        step();
        clr_err = 1'b0;
        chk("t3 cleared", 64'(reject_err), 64'd0);
        clr_err = 1'b1;
        push(mk(5, 480, 5, 5, 2));
        clr_err = 1'b0;
        chk("t3 reject wins", 64'(reject_err), 64'd1);
        clr_err = 1'b1;
        step();
        clr_err = 1'b0;
        push(mk(639, 479, 639, 479, 3));
        chk("t3 edge valid", 64'(count), 64'd1);
        out_rtr = 1'b1;
        step();
        out_rtr = 1'b0;

        // Mixed accept/issue with the engine toggling ready.
        for (int i = 0; i < 5; i++) push(mk(100 + i, 10, 200, 20, i));
        chk("t4 count5", 64'(count), 64'd5);
        for (int i = 0; i < 16; i++) begin
            in_op   = mk(300 + i, 30, 400, 40, i);
            in_rts  = 1'b1;
            out_rtr = i[0];
            step();
        end
        in_rts = 1'b0;
        chk("t4 net count", 64'(count), 64'd13);
        out_rtr = 1'b1;
        repeat (20) step();
        chk("t4 drained", 64'(count), 64'd0);

        // Flush with a command offered in the same cycle.
        out_rtr = 1'b0;
        for (int i = 0; i < 8; i++) push(mk(i, 1, 2, 3, 4));
        flush  = 1'b1;
        in_op  = mk(50, 50, 60, 60, 7);
        in_rts = 1'b1;
        #1;
        chk("t5 in_rtr flush", 64'(in_rtr), 64'd0);
        step();
        flush  = 1'b0;
        in_rts = 1'b0;
        chk("t5 count", 64'(count), 64'd0);
        chk("t5 out_rts", 64'(out_rts), 64'd0);
        push(mk(7, 8, 9, 10, 12'hABC));
        chk("t5 repush", 64'(out_op), 64'(mk(7, 8, 9, 10, 12'hABC)));
        out_rtr = 1'b1;
        step();
        out_rtr = 1'b0;

        // Reset in the middle of a stream with a pending error.
        for (int i = 0; i < 10; i++) push(mk(i, 2, 3, 4, 5));
        push(mk(700, 0, 0, 0, 0));
        rst_ = 1'b1;
        step();
        rst_ = 1'b0;
        chk("t6 count", 64'(count), 64'd0);
        chk("t6 out_rts", 64'(out_rts), 64'd0);
        chk("t6 out_op", 64'(out_op), 64'd0);
        chk("t6 busy", 64'(busy), 64'd0);
        chk("t6 err", 64'(reject_err), 64'd0);
`ifdef DRAW_CMD_QUEUE_STATS_EN
        chk("t6 issued_cnt", 64'(issued_cnt), 64'd0);
`endif
        step();
        step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/draw_cmd_queue.md
# draw_cmd_queue

Command-side transmitter for the line drawing engine: buffers 52-bit line-draw commands from a host/command source and presents them one at a time on the rts/rtr command port that line_drawing_engine consumes (`in_op`/`in_rts`/`in_rtr`). It replaces the static tied-high test line, runs in the clk25 domain, and range-checks every command against the 640x480 frame before queuing it.

## Interface
Parameters:
- `DEPTH`, 16: total command capacity including the output register; power of two, ≥ 2.
- `AW`, `$clog2(DEPTH)`: pointer width; `count` is `AW+1` bits.

Ports:
- `clk`  in  1  system clock (clk25 domain).
- `rst_`  in  1  reset; synchronous, active-high.
- `in_op`  in  52  command: x0[51:42], y0[41:32], x1[31:22], y1[21:12], color[11:0].
- `in_rts`  in  1  source has a command.
- `in_rtr`  out  1  queue can accept.
- `out_op`  out  52  command to line drawing engine.
- `out_rts`  out  1  `out_op` valid.
- `out_rtr`  in  1  line drawing engine ready.
- `flush`  in  1  discard all queued commands.
- `clr_err`  in  1  clear `reject_err`.
- `count`  out  AW+1  commands held (FIFO + output register), 0..DEPTH.
- `busy`  out  1  `count != 0`.
- `reject_err`  out  1  sticky: an out-of-range command was dropped.

## Operation
- Accept: `in_rts && in_rtr`. `in_rtr = !flush && (count < DEPTH)`; combinational from registered state only, no path from `out_rtr`.
- Range check on accept: valid iff x0, x1 ≤ 639 and y0, y1 ≤ 479 (10-bit unsigned compares). Invalid: handshake completes, command dropped, `count` unchanged, `reject_err` set next cycle.
- Storage: (DEPTH-1)-entry circular FIFO plus one output register; wrap pointers modulo DEPTH-1 storage slots, or equivalent; `count` is the authoritative occupancy.
- Output stage FSM:
  - EMPTY: `out_rts=0`. Accepted valid command (or FIFO non-empty) loads output register -> FULL.
  - FULL: `out_rts=1`, `out_op` stable until transfer. On `out_rts && out_rtr`: load next FIFO head if FIFO non-empty (stay FULL), else load a same-cycle accepted command if present (stay FULL), else -> EMPTY.
- Order strictly preserved; no command issued twice or skipped.
- Simultaneous accept and issue: `count` unchanged.
- `flush`: next cycle `count=0`, pointers reset, FSM EMPTY, `out_rts=0`. Transfer completing in the flush cycle counts as issued; same-cycle input is refused (`in_rtr=0`). `reject_err` unaffected.
- `clr_err` clears `reject_err` next cycle; a reject in the same cycle wins (stays 1).

## Timing
- Reset (`rst_=1` at clock edge): `out_rts=0`, `out_op=0`, `count=0`, `busy=0`, `reject_err=0`, FSM EMPTY; `in_rtr=1` in first cycle after reset deasserts.
- Latency: valid command accepted into empty queue at edge N is on `out_op` with `out_rts=1` after edge N (visible cycle N+1).
- Throughput: one accept and one issue per cycle sustained.
- `count` and `reject_err` registered, updated one edge after the event.
- Reset mid-operation discards all contents identically to flush and clears `reject_err`.

## Configuration
- `DRAW_CMD_QUEUE_STATS_EN` defined: adds outputs `issued_cnt` (out, 16, increments on each `out_rts && out_rtr`, wraps 65535->0) and `reject_cnt` (out, 8, increments per dropped command, saturates at 255); both 0 on reset, not cleared by `flush` or `clr_err`.
- Undefined: those ports and counters absent; all other behaviour identical.

## Test plan
- Reset, then push (0,0)-(639,479) color FFF with `out_rtr=1` -> `out_rts` high exactly one cycle later, `out_op` matches, `count` 1 then 0.
- `out_rtr=0`, push 20 valid commands back-to-back -> exactly 16 accepted, `in_rtr=0` at `count=16`; release `out_rtr` -> 16 commands out in order, one per cycle.
- Push x1=640 (or y0=480) -> dropped, `reject_err=1`, `count` unchanged; `clr_err` -> 0; with STATS_EN `reject_cnt=1`.
- `count=5`, `out_rtr` toggling 1/0 while pushing every cycle -> output sequence equals input sequence, no loss/duplication, `count` tracks net occupancy.
- Assert `flush` with 8 queued and `in_rts=1` -> next cycle `count=0`, `out_rts=0`, flush-cycle input not accepted; subsequent push issued normally.
- Assert `rst_` mid-stream with 10 queued -> all outputs at reset values next cycle; with STATS_EN `issued_cnt=0`.
